sub_nbits: RTL and testbench

Parameterised n-bit two's-complement subtractor with borrow-in, producing difference, borrow-out and signed-overflow flags. Implemented as a ripple-borrow chain of 1-bit full-subtractor cells, with outputs registered on the system clock. Used as a standalone arithmetic primitive in datapaths and as a building block for wider ALU slices.

---
 rtl/sub_nbits_pkg.sv | 4 +
 rtl/sub_nbits_bit.sv | 11 +
 rtl/sub_nbits.sv | 46 ++++
 tb/tb_sub_nbits.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sub_nbits_pkg.sv
// Shared constants for the ripple-borrow subtractor slice.
package sub_nbits_pkg;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/sub_nbits_bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
module sub_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/sub_nbits.sv
// n-bit two's-complement subtractor with borrow-in; ripple-borrow core and
// registered difference, borrow-out and signed-overflow outputs.
module sub_nbits
    import sub_nbits_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         overflow
);
    logic [n:0]   borrow;
    logic [n-1:0] diff;

    assign borrow[0] = cin;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_cell
            sub_1bit u_cell (
                .x    (x[gi]),
                .y    (y[gi]),
                .bin  (borrow[gi]),
                .d    (diff[gi]),
                .bout (borrow[gi+1])
            );
        end
    endgenerate

    // Signed overflow: borrow into the MSB disagrees with borrow out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            s        <= diff;
            cout     <= borrow[n];
            overflow <= borrow[n] ^ borrow[n-1];
        end
    end
endmodule

// File: tb/tb_sub_nbits.sv
// Self-checking bench for sub_nbits at n=4 (exhaustive + literals) and n=8 (random).
module tb_sub_nbits;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] x4 = 4'h5, y4 = 4'h3;
    logic       c4 = 1'b1;
    logic [7:0] x8 = 8'hA5, y8 = 8'h3C;
    logic       c8 = 1'b1;
    logic [3:0] s4;
    logic       co4, ov4;
    logic [7:0] s8;
    logic       co8, ov8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_nbits #(.n(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .cin(c4),
        .s(s4), .cout(co4), .overflow(ov4)
    );
    sub_nbits #(.n(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .cin(c8),
        .s(s8), .cout(co8), .overflow(ov8)
    );

    // Reference: plain integer arithmetic; returns {overflow, cout, s[7:0]}.
    function automatic logic [9:0] model(input int w, input int a, input int b, input int c);
        int d, sa, sb, sd, smod;
        logic [9:0] r;
        d    = a - b - c;
        smod = d & ((1 << w) - 1);
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sd   = sa - sb - c;
        r    = '0;
        r[7:0] = smod[7:0];
        r[8]   = (d < 0);
        r[9]   = (sd < -(1 << (w - 1))) || (sd > (1 << (w - 1)) - 1);
        return r;
    endfunction

    logic [9:0] exp4, exp8;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp4 <= '0;
            exp8 <= '0;
        end else begin
            exp4 <= model(4, int'(x4), int'(y4), int'(c4));
            exp8 <= model(8, int'(x8), int'(y8), int'(c8));
        end
    end

    // Every-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        checks++;
        if ({ov4, co4, s4} !== {exp4[9], exp4[8], exp4[3:0]}) begin
            errors++;
            $display("FAIL cyc4 x=%h y=%h cin=%b got s=%h cout=%b ov=%b want s=%h cout=%b ov=%b",
                     x4, y4, c4, s4, co4, ov4, exp4[3:0], exp4[8], exp4[9]);
        end
        checks++;
        if ({ov8, co8, s8} !== exp8) begin
            errors++;
            $display("FAIL cyc8 x=%h y=%h cin=%b got s=%h cout=%b ov=%b want s=%h cout=%b ov=%b",
                     x8, y8, c8, s8, co8, ov8, exp8[7:0], exp8[8], exp8[9]);
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({s4, co4, ov4} !== 6'd0 || {s8, co8, ov8} !== 10'd0) begin
            errors++;
            $display("FAIL %s got s4=%h c4=%b o4=%b s8=%h c8=%b o8=%b want all 0",
                     name, s4, co4, ov4, s8, co8, ov8);
        end else
            $display("%s: outputs zero in reset", name);
    endtask

    // Apply one n=4 vector, wait for it to be registered, check DUT and model against literals.
    task automatic lit(input string name, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] es, input logic ec, input logic eo);
        logic [9:0] m;
        @(posedge clk); #2;
        x4 = a; y4 = b; c4 = c;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({s4, co4, ov4} !== {es, ec, eo}) begin
            errors++;
            $display("FAIL %s dut s=%h cout=%b ov=%b want s=%h cout=%b ov=%b",
                     name, s4, co4, ov4, es, ec, eo);
        end else
            $display("%s: x=%h y=%h cin=%b -> s=%h cout=%b ov=%b", name, a, b, c, s4, co4, ov4);
        m = model(4, int'(a), int'(b), int'(c));
        checks++;
        if ({m[3:0], m[8], m[9]} !== {es, ec, eo}) begin
            errors++;
            $display("FAIL %s_model s=%h cout=%b ov=%b want s=%h cout=%b ov=%b",
                     name, m[3:0], m[8], m[9], es, ec, eo);
        end
    endtask

    initial begin
        // Asynchronous reset with nonzero inputs, no clock edge yet.
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk); #2 rst_n = 1'b1;

        lit("first_load", 4'h5, 4'h3, 1'b1, 4'h1, 1'b0, 1'b0);
        lit("neg_one",    4'h5, 4'h6, 1'b0, 4'hF, 1'b1, 1'b0);
        lit("neg_two",    4'h5, 4'h6, 1'b1, 4'hE, 1'b1, 1'b0);
        lit("pos_ovf",    4'h6, 4'hD, 1'b1, 4'h8, 1'b1, 1'b1);
        lit("neg_sub",    4'hC, 4'hB, 1'b0, 4'h1, 1'b0, 1'b0);
        lit("neg_ovf",    4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
        lit("zero_cin",   4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
        lit("ff_wrap",    4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);

        // Exhaustive n=4 sweep alongside random n=8 vectors.
        for (int i = 0; i < 512; i++) begin
            @(posedge clk); #2;
            x4 = i[3:0]; y4 = i[7:4]; c4 = i[8];
            x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
        end

        // Random stream with a mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            x4 = 4'($urandom); y4 = 4'($urandom); c4 = 1'($urandom);
            x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
            if (i == 150) begin
                rst_n = 1'b0;
                #1 check_zero("reset_mid");
                @(posedge clk); #1 check_zero("reset_held");
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk); @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
